bus_control: RTL and testbench

BUS_CONTROL -- requirements
Module: bus_control

---
 rtl/bus_control_if.sv | 25 ++
 rtl/bus_control.sv | 157 +++++++++++++++
 tb/tb_bus_control.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_control_if.sv
// Bus-control handshake bundle: start request, instruction word and status in,
// datapath select/enable strobes out. The controller attaches through the
// slave modport; whatever issues instructions uses the master modport.
interface bus_control_if;
    logic        run;
    logic [15:0] din;
    logic        gnz;
    logic [9:0]  bus_sel;
    logic [7:0]  rin;
    logic        ain;
    logic        gin;
    logic        add_sub;
    logic        ir_in;
    logic        done;

    modport master (
        output run, din, gnz,
        input  bus_sel, rin, ain, gin, add_sub, ir_in, done
    );

    modport slave (
        input  run, din, gnz,
        output bus_sel, rin, ain, gin, add_sub, ir_in, done
    );
endinterface

// File: rtl/bus_control.sv
// Control unit for a simple 8-register processor datapath.
// A 2-bit step counter (T0..T3) plus a 9-bit instruction register (III XXX YYY)
// decode into the one-hot bus select and register/ALU enables.
// Optional feature: define BUS_CONTROL_MVNZ_EN to make opcode 110 a
// conditional move (mvnz Rx,Ry) gated by the gnz status input; otherwise
// opcode 110 is an undefined opcode and executes as a NOP.
module bus_control (
    input  logic          clk,
    input  logic          rst,
    bus_control_if.slave  bus
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    logic [1:0] step_q, step_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;

    logic [9:0] bus_sel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       add_sub;
    logic       ir_in_raw;
    logic       done;

    assign opcode = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];

    // Only the low 9 bits of the word form an instruction; the upper bits are
    // immediate data consumed by the datapath, not by this controller.
`ifdef BUS_CONTROL_MVNZ_EN
    logic unused_inputs;
    assign unused_inputs = ^bus.din[15:9];
`else
    logic unused_inputs;
    assign unused_inputs = ^{bus.din[15:9], bus.gnz};
`endif

    // Decode step counter and IR into next state and datapath strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves a variable unassigned, which would infer a latch; combinational
        // blocks use blocking (=) assignments.
        step_d    = step_q;
        ir_d      = ir_q;
        bus_sel   = '0;
        rin       = '0;
        ain       = 1'b0;
        gin       = 1'b0;
        add_sub   = 1'b0;
        ir_in_raw = 1'b0;
        done      = 1'b0;

        case (step_q)
            T0: begin
                if (bus.run) begin
                    ir_in_raw = 1'b1;
                    ir_d      = bus.din[8:0];
                    step_d    = T1;
                end
            end

            T1: begin
                step_d = T0;
                case (opcode)
                    OP_MV: begin
                        bus_sel[ry] = 1'b1;
                        rin[rx]     = 1'b1;
                        done        = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel[9] = 1'b1;
                        rin[rx]    = 1'b1;
                        done       = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel[rx] = 1'b1;
                        ain         = 1'b1;
                        step_d      = T2;
                    end
`ifdef BUS_CONTROL_MVNZ_EN
                    OP_MVNZ: begin
                        if (bus.gnz) begin
                            bus_sel[ry] = 1'b1;
                            rin[rx]     = 1'b1;
                        end
                        done = 1'b1;
                    end
`endif
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end

            T2: begin
                // Only add/sub ever reach T2; anything else falls back to idle.
                step_d = T0;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    bus_sel[ry] = 1'b1;
                    gin         = 1'b1;
                    add_sub     = opcode[0];
                    step_d      = T3;
                end
            end

            T3: begin
                step_d = T0;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    bus_sel[8] = 1'b1;
                    rin[rx]    = 1'b1;
                    done       = 1'b1;
                end
            end

            default: step_d = T0;
        endcase
    end

    // Step counter and instruction register; reset forces idle without a clock.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values; the reset branch is asynchronous.
        if (rst) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // The state is already T0 during reset, so every strobe is zero except the
    // capture strobe, which would otherwise follow run straight through.
    assign bus.bus_sel = bus_sel;
    assign bus.rin     = rin;
    assign bus.ain     = ain;
    assign bus.gin     = gin;
    assign bus.add_sub = add_sub;
    assign bus.ir_in   = ir_in_raw & ~rst;
    assign bus.done    = done;

endmodule

// File: tb/tb_bus_control.sv
// Directed testbench for bus_control: hand-computed strobe vectors per step,
// covering reset behaviour, mv/mvi/add/sub/NOP, the optional mvnz opcode
// (BUS_CONTROL_MVNZ_EN) and back-to-back issue with run held high.
module tb_bus_control;

    logic clk;
    logic rst;

    bus_control_if bus ();

    bus_control u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one full cycle; inputs change and outputs are sampled in the low phase.
    task automatic tick();
        @(negedge clk);
    endtask

    // Compare the full strobe vector {bus_sel, rin, ain, gin, add_sub, ir_in, done}
    // and confirm at most one bus select bit is driven.
    task automatic expect_out(input string tag, input logic [9:0] bs, input logic [7:0] rn,
                              input logic a, input logic g, input logic as,
                              input logic ir, input logic dn);
        #2;
        check(tag, {9'b0, bus.bus_sel, bus.rin, bus.ain, bus.gin, bus.add_sub, bus.ir_in, bus.done},
                   {9'b0, bs, rn, a, g, as, ir, dn});
        check({tag, "_onehot"}, 32'($countones(bus.bus_sel) <= 1), 32'd1);
    endtask

    localparam logic [15:0] I_MVI_R0   = 16'h0040; // 001_000_000
    localparam logic [15:0] I_MV_R2_R5 = 16'h0015; // 000_010_101
    localparam logic [15:0] I_SUB_R1R3 = 16'h00CB; // 011_001_011
    localparam logic [15:0] I_ADD_R3R3 = 16'h009B; // 010_011_011
    localparam logic [15:0] I_UNDEF    = 16'h01C0; // 111_000_000
    localparam logic [15:0] I_MVNZ     = 16'h0181; // 110_000_001

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        bus.run  = 1'b1;
        bus.din  = I_MV_R2_R5;
        bus.gnz  = 1'b0;

        // Reset held with run high: everything zero, including the capture strobe.
        tick();
        expect_out("rst_idle", 10'h000, 8'h00, 0, 0, 0, 0, 0);
        tick();
        expect_out("rst_idle2", 10'h000, 8'h00, 0, 0, 0, 0, 0);

        // Release with run low: stays in T0.
        bus.run = 1'b0;
        rst     = 1'b0;
        tick();
        expect_out("idle_run0", 10'h000, 8'h00, 0, 0, 0, 0, 0);
        tick();
        expect_out("idle_run0_b", 10'h000, 8'h00, 0, 0, 0, 0, 0);

        // mvi R0,#D: immediate is on din during T1.
        bus.run = 1'b1;
        bus.din = I_MVI_R0;
        expect_out("mvi_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.run = 1'b0;
        bus.din = 16'h00A5;
        expect_out("mvi_t1", 10'h200, 8'h01, 0, 0, 0, 0, 1);
        tick();
        expect_out("mvi_after", 10'h000, 8'h00, 0, 0, 0, 0, 0);

        // mv R2,R5: two cycles from capture to done.
        bus.run = 1'b1;
        bus.din = I_MV_R2_R5;
        expect_out("mv_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.run = 1'b0;
        expect_out("mv_t1", 10'h020, 8'h04, 0, 0, 0, 0, 1);
        tick();
        expect_out("mv_after", 10'h000, 8'h00, 0, 0, 0, 0, 0);

        // sub R1,R3; run held high in T1-T3 must be ignored.
        bus.run = 1'b1;
        bus.din = I_SUB_R1R3;
        expect_out("sub_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.din = I_MVI_R0;
        expect_out("sub_t1", 10'h002, 8'h00, 1, 0, 0, 0, 0);
        tick();
        expect_out("sub_t2", 10'h008, 8'h00, 0, 1, 1, 0, 0);
        tick();
        bus.run = 1'b0;
        expect_out("sub_t3", 10'h100, 8'h02, 0, 0, 0, 0, 1);
        tick();
        expect_out("sub_after", 10'h000, 8'h00, 0, 0, 0, 0, 0);

        // add R3,R3: same register read in T1 and T2.
        bus.run = 1'b1;
        bus.din = I_ADD_R3R3;
        expect_out("add_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.run = 1'b0;
        expect_out("add_t1", 10'h008, 8'h00, 1, 0, 0, 0, 0);
        tick();
        expect_out("add_t2", 10'h008, 8'h00, 0, 1, 0, 0, 0);
        tick();
        expect_out("add_t3", 10'h100, 8'h08, 0, 0, 0, 0, 1);
        tick();

        // Undefined opcode executes as a one-step NOP.
        bus.run = 1'b1;
        bus.din = I_UNDEF;
        expect_out("nop_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.run = 1'b0;
        expect_out("nop_t1", 10'h000, 8'h00, 0, 0, 0, 0, 1);
        tick();
        expect_out("nop_after", 10'h000, 8'h00, 0, 0, 0, 0, 0);

        // Opcode 110 with gnz low, then high.
        bus.run = 1'b1;
        bus.din = I_MVNZ;
        bus.gnz = 1'b0;
        tick();
        bus.run = 1'b0;
        expect_out("mvnz_gnz0", 10'h000, 8'h00, 0, 0, 0, 0, 1);
        tick();
        bus.run = 1'b1;
        bus.gnz = 1'b1;
        tick();
        bus.run = 1'b0;
`ifdef BUS_CONTROL_MVNZ_EN
        expect_out("mvnz_gnz1", 10'h002, 8'h01, 0, 0, 0, 0, 1);
`else
        expect_out("mvnz_gnz1", 10'h000, 8'h00, 0, 0, 0, 0, 1);
`endif
        tick();
        bus.gnz = 1'b0;

        // Back-to-back mv, add, mvi with run held high throughout.
        bus.run = 1'b1;
        bus.din = I_MV_R2_R5;
        expect_out("b2b_mv_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.din = I_ADD_R3R3;
        expect_out("b2b_mv_t1", 10'h020, 8'h04, 0, 0, 0, 0, 1);
        tick();
        expect_out("b2b_add_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.din = I_MVI_R0;
        expect_out("b2b_add_t1", 10'h008, 8'h00, 1, 0, 0, 0, 0);
        tick();
        expect_out("b2b_add_t2", 10'h008, 8'h00, 0, 1, 0, 0, 0);
        tick();
        expect_out("b2b_add_t3", 10'h100, 8'h08, 0, 0, 0, 0, 1);
        tick();
        expect_out("b2b_mvi_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.run = 1'b0;
        bus.din = 16'h00A5;
        expect_out("b2b_mvi_t1", 10'h200, 8'h01, 0, 0, 0, 0, 1);
        tick();

        // Reset mid-T2 of add: abandon at once, no done, then stay idle.
        bus.run = 1'b1;
        bus.din = I_ADD_R3R3;
        tick();
        bus.run = 1'b0;
        tick();
        expect_out("abort_t2", 10'h008, 8'h00, 0, 1, 0, 0, 0);
        rst     = 1'b1;
        bus.run = 1'b1;
        expect_out("abort_rst", 10'h000, 8'h00, 0, 0, 0, 0, 0);
        tick();
        expect_out("abort_rst_hold", 10'h000, 8'h00, 0, 0, 0, 0, 0);
        bus.run = 1'b0;
        rst     = 1'b0;
        tick();
        expect_out("abort_idle1", 10'h000, 8'h00, 0, 0, 0, 0, 0);
        tick();
        expect_out("abort_idle2", 10'h000, 8'h00, 0, 0, 0, 0, 0);

        // First instruction after reset follows T0 rules.
        bus.run = 1'b1;
        bus.din = I_MV_R2_R5;
        expect_out("post_rst_t0", 10'h000, 8'h00, 0, 0, 0, 1, 0);
        tick();
        bus.run = 1'b0;
        expect_out("post_rst_t1", 10'h020, 8'h04, 0, 0, 0, 0, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
